// File: rtl/lavatory_arbiter_pkg.sv
//==============================================================================
// Module      : lav_pkg
// Description : Shared types and constants for the lavatory arbiter: the
//               per-lavatory state encoding, the passenger classes and the
//               fixed lavatory indices.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package lav_pkg;

   // Per-lavatory state, also the encoding presented on lav_state
   typedef enum logic [1:0] {
      FREE  = 2'b00,
      OCC   = 2'b01,
      CLEAN = 2'b10
   } lav_state_t;

   // Passenger class; also used as the round-robin pointer value
   typedef enum logic {
      WOMEN = 1'b0,
      MEN   = 1'b1
   } class_t;

   // Lavatory indices: women-only, men-only, shared
   localparam logic [1:0] LAV_W = 2'd0;
   localparam logic [1:0] LAV_M = 2'd1;
   localparam logic [1:0] LAV_S = 2'd2;

endpackage

`default_nettype wire

// File: rtl/lavatory_arbiter_if.sv
//==============================================================================
// Module      : lavatory_arbiter_if
// Description : Request/vacate inputs and grant/status outputs of the
//               lavatory arbiter. The slave side is the arbiter, the master
//               side is the board logic (or a testbench).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface lavatory_arbiter_if #(
   parameter int QW = 3
);
   logic          req_w;
   logic          req_m;
   logic [2:0]    vacate;
   logic          grant_w;
   logic [1:0]    grant_w_lav;
   logic          grant_m;
   logic [1:0]    grant_m_lav;
   logic [QW-1:0] q_w;
   logic [QW-1:0] q_m;
   logic          drop_w;
   logic          drop_m;
   logic [5:0]    lav_state;
   logic [2:0]    overstay;
   logic          disp_w;
   logic          disp_m;

   modport master (
      output req_w, req_m, vacate,
      input  grant_w, grant_w_lav, grant_m, grant_m_lav, q_w, q_m,
             drop_w, drop_m, lav_state, overstay, disp_w, disp_m
   );

   modport slave (
      input  req_w, req_m, vacate,
      output grant_w, grant_w_lav, grant_m, grant_m_lav, q_w, q_m,
             drop_w, drop_m, lav_state, overstay, disp_w, disp_m
   );
endinterface

`default_nettype wire

// File: rtl/lavatory_arbiter_slot.sv
//==============================================================================
// Module      : lav_slot
// Description : One lavatory: FREE/OCC/CLEAN state machine, cleaning
//               countdown and saturating occupancy timer with overstay flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lav_slot #(
   parameter int CLEAN_CYC   = 4,
   parameter int OCC_TIMEOUT = 255,
   parameter int TW          = 8
) (
   input  wire logic       clk_2,
   input  wire logic       rst_n,
   input  wire logic       grant_i,
   input  wire logic       vacate_i,
   output logic [1:0]      state_o,
   output logic            overstay_o
);
   import lav_pkg::*;

   localparam logic [1:0] C_ST_FREE  = FREE;
   localparam logic [1:0] C_ST_OCC   = OCC;
   localparam logic [1:0] C_ST_CLEAN = CLEAN;

   // Countdown holds CLEAN_CYC-1 .. 0, so log2(CLEAN_CYC) bits suffice
   localparam int CW = (CLEAN_CYC > 1) ? $clog2(CLEAN_CYC) : 1;
   localparam logic [CW-1:0] C_CLEAN_LOAD = CW'(CLEAN_CYC - 1);
   localparam logic [TW-1:0] C_TIMEOUT    = TW'(OCC_TIMEOUT);

   logic [1:0]    state_q,    state_d;
   logic [CW-1:0] clean_q,    clean_d;
   logic [TW-1:0] timer_q,    timer_d;
   logic          overstay_q, overstay_d;

   // Next-state: occupy on grant, clean on vacate, free after the countdown
   always_comb begin
      state_d = state_q;
      clean_d = clean_q;
      timer_d = timer_q;
      case (state_q)
         C_ST_FREE: begin
            if (grant_i) begin
               state_d = C_ST_OCC;
               timer_d = '0;
            end
         end
         C_ST_OCC: begin
            if (vacate_i) begin
               state_d = C_ST_CLEAN;
               clean_d = C_CLEAN_LOAD;
               timer_d = '0;
            end else if (timer_q != C_TIMEOUT) begin
               timer_d = timer_q + 1'b1;
            end
         end
         C_ST_CLEAN: begin
            // Last CLEAN cycle is the one where the countdown reads zero
            if (clean_q == '0) begin
               state_d = C_ST_FREE;
            end else begin
               clean_d = clean_q - 1'b1;
            end
         end
         default: begin
            state_d = C_ST_FREE;
         end
      endcase
      overstay_d = (state_d == C_ST_OCC) && (timer_d == C_TIMEOUT);
   end

   // State, counters and overstay flag registers
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= C_ST_FREE;
         clean_q    <= '0;
         timer_q    <= '0;
         overstay_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clean_q    <= clean_d;
         timer_q    <= timer_d;
         overstay_q <= overstay_d;
      end
   end

   assign state_o    = state_q;
   assign overstay_o = overstay_q;

endmodule

`default_nettype wire

// File: rtl/lavatory_arbiter.sv
//==============================================================================
// Module      : lavatory_arbiter
// Description : Shares three lavatories between women and men. Keeps a
//               saturating waiting count per class, grants free eligible
//               lavatories (round-robin on the shared one) and tracks each
//               lavatory through occupy/clean with an overstay alarm.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lavatory_arbiter #(
   parameter int QMAX        = 7,
   parameter int CLEAN_CYC   = 4,
   parameter int OCC_TIMEOUT = 255,
   parameter int TW          = 8,
   parameter int QW          = $clog2(QMAX + 1)
) (
   input  wire logic          clk_2,
   input  wire logic          rst_n,
   lavatory_arbiter_if.slave  bus
);
   import lav_pkg::*;

   localparam logic [QW-1:0] C_QMAX = QW'(QMAX);

   // Returns {drop, next_count}; an arrival at a full queue is only
   // accepted when a same-class grant frees a slot in the same cycle.
   function automatic logic [QW:0] f_queue_next(
      input logic [QW-1:0] q,
      input logic          req,
      input logic          grant
   );
      logic [QW-1:0] q_n;
      logic          drop;
      q_n  = q;
      drop = 1'b0;
      if (req && !grant) begin
         if (q == C_QMAX) begin
            drop = 1'b1;
         end else begin
            q_n = q + 1'b1;
         end
      end else if (!req && grant) begin
         q_n = q - 1'b1;
      end
      return {drop, q_n};
   endfunction

   logic [5:0]    w_lav_state;
   logic [2:0]    w_overstay;
   logic [2:0]    w_free;
   logic [2:0]    w_lav_grant;
   logic          w_w_lav0, w_w_want2, w_w_lav2, w_gw;
   logic          w_m_lav1, w_m_want2, w_m_lav2, w_gm;

   logic [QW-1:0] q_w_q, q_w_d;
   logic [QW-1:0] q_m_q, q_m_d;
   logic          drop_w_q, drop_w_d;
   logic          drop_m_q, drop_m_d;
   logic          grant_w_q, grant_m_q;
   logic [1:0]    grant_w_lav_q, grant_w_lav_d;
   logic [1:0]    grant_m_lav_q, grant_m_lav_d;
   class_t        rr_ptr_q, rr_ptr_d;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_slot
         lav_slot #(
            .CLEAN_CYC   (CLEAN_CYC),
            .OCC_TIMEOUT (OCC_TIMEOUT),
            .TW          (TW)
         ) u_slot (
            .clk_2       (clk_2),
            .rst_n       (rst_n),
            .grant_i     (w_lav_grant[gi]),
            .vacate_i    (bus.vacate[gi]),
            .state_o     (w_lav_state[2*gi +: 2]),
            .overstay_o  (w_overstay[gi])
         );
         assign w_free[gi] = (w_lav_state[2*gi +: 2] == FREE);
      end
   endgenerate

   // Grant decision from registered counts and lavatory states
   always_comb begin
      w_w_lav0  = (q_w_q != '0) && w_free[LAV_W];
      w_w_want2 = (q_w_q != '0) && !w_free[LAV_W] && w_free[LAV_S];
      w_m_lav1  = (q_m_q != '0) && w_free[LAV_M];
      w_m_want2 = (q_m_q != '0) && !w_free[LAV_M] && w_free[LAV_S];
      // On a shared-lavatory conflict the class not last served wins
      w_w_lav2  = w_w_want2 && (!w_m_want2 || (rr_ptr_q == MEN));
      w_m_lav2  = w_m_want2 && (!w_w_want2 || (rr_ptr_q == WOMEN));
      w_gw      = w_w_lav0 | w_w_lav2;
      w_gm      = w_m_lav1 | w_m_lav2;

      w_lav_grant[LAV_W] = w_w_lav0;
      w_lav_grant[LAV_M] = w_m_lav1;
      w_lav_grant[LAV_S] = w_w_lav2 | w_m_lav2;

      grant_w_lav_d = w_gw ? (w_w_lav2 ? LAV_S : LAV_W) : 2'd0;
      grant_m_lav_d = w_gm ? (w_m_lav2 ? LAV_S : LAV_M) : 2'd0;

      rr_ptr_d = rr_ptr_q;
      if (w_w_lav2) begin
         rr_ptr_d = WOMEN;
      end else if (w_m_lav2) begin
         rr_ptr_d = MEN;
      end

      {drop_w_d, q_w_d} = f_queue_next(q_w_q, bus.req_w, w_gw);
      {drop_m_d, q_m_d} = f_queue_next(q_m_q, bus.req_m, w_gm);
   end

   // Queue counts, grant/drop pulses and round-robin pointer
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         q_w_q         <= '0;
         q_m_q         <= '0;
         drop_w_q      <= 1'b0;
         drop_m_q      <= 1'b0;
         grant_w_q     <= 1'b0;
         grant_m_q     <= 1'b0;
         grant_w_lav_q <= 2'd0;
         grant_m_lav_q <= 2'd0;
         rr_ptr_q      <= MEN;
      end else begin
         q_w_q         <= q_w_d;
         q_m_q         <= q_m_d;
         drop_w_q      <= drop_w_d;
         drop_m_q      <= drop_m_d;
         grant_w_q     <= w_gw;
         grant_m_q     <= w_gm;
         grant_w_lav_q <= grant_w_lav_d;
         grant_m_lav_q <= grant_m_lav_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

   assign bus.grant_w     = grant_w_q;
   assign bus.grant_w_lav = grant_w_lav_q;
   assign bus.grant_m     = grant_m_q;
   assign bus.grant_m_lav = grant_m_lav_q;
   assign bus.q_w         = q_w_q;
   assign bus.q_m         = q_m_q;
   assign bus.drop_w      = drop_w_q;
   assign bus.drop_m      = drop_m_q;
   assign bus.lav_state   = w_lav_state;
   assign bus.overstay    = w_overstay;
   assign bus.disp_w      = w_free[LAV_W] | w_free[LAV_S];
   assign bus.disp_m      = w_free[LAV_M] | w_free[LAV_S];

endmodule

`default_nettype wire

// File: tb/tb_lavatory_arbiter.sv
//==============================================================================
// Module      : tb_lavatory_arbiter
// Description : Scoreboard bench for lavatory_arbiter. Each stimulus cycle
//               advances a plain-integer reference model and queues the
//               expected post-edge outputs; a monitor pops and compares.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lavatory_arbiter;
   import lav_pkg::*;

   localparam int QMAX        = 7;
   localparam int CLEAN_CYC   = 4;
   localparam int OCC_TIMEOUT = 10;
   localparam int TW          = 8;
   localparam int QW          = 3;

   typedef struct packed {
      logic       gw;
      logic [1:0] gwl;
      logic       gm;
      logic [1:0] gml;
      logic [3:0] qw;
      logic [3:0] qm;
      logic       dw;
      logic       dm;
      logic [5:0] ls;
      logic [2:0] ov;
      logic       pw;
      logic       pm;
   } exp_t;

   logic clk_2 = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk_2 = ~clk_2;

   lavatory_arbiter_if #(.QW(QW)) bus();

   lavatory_arbiter #(
      .QMAX        (QMAX),
      .CLEAN_CYC   (CLEAN_CYC),
      .OCC_TIMEOUT (OCC_TIMEOUT),
      .TW          (TW),
      .QW          (QW)
   ) dut (
      .clk_2 (clk_2),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb[$];

   // Reference model: 0=free 1=occupied 2=cleaning; rr 0=women 1=men
   int m_q[2];
   int m_st[3];
   int m_left[3];
   int m_occ[3];
   int m_rr;

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_st[i] = 0; m_left[i] = 0; m_occ[i] = 0;
      end
      m_q[0] = 0; m_q[1] = 0; m_rr = 1;
      sb.delete();
   endtask

   task automatic model_step(input bit rw, input bit rm, input bit [2:0] vac);
      exp_t e;
      int   gw_lav, gm_lav;
      bit   g;
      e = '0;
      gw_lav = -1;
      gm_lav = -1;
      if (m_q[0] > 0) begin
         if (m_st[0] == 0) gw_lav = 0;
         else if (m_st[2] == 0) gw_lav = 2;
      end
      if (m_q[1] > 0) begin
         if (m_st[1] == 0) gm_lav = 1;
         else if (m_st[2] == 0) gm_lav = 2;
      end
      if (gw_lav == 2 && gm_lav == 2) begin
         if (m_rr == 1) gm_lav = -1;
         else gw_lav = -1;
      end
      if (gw_lav == 2) m_rr = 0;
      if (gm_lav == 2) m_rr = 1;

      e.dw = rw && (m_q[0] == QMAX) && (gw_lav < 0);
      e.dm = rm && (m_q[1] == QMAX) && (gm_lav < 0);
      if (rw && !e.dw) m_q[0]++;
      if (rm && !e.dm) m_q[1]++;
      if (gw_lav >= 0) m_q[0]--;
      if (gm_lav >= 0) m_q[1]--;

      for (int i = 0; i < 3; i++) begin
         g = (gw_lav == i) || (gm_lav == i);
         case (m_st[i])
            0: if (g) begin m_st[i] = 1; m_occ[i] = 0; end
            1: begin
               if (vac[i]) begin
                  m_st[i] = 2; m_left[i] = CLEAN_CYC;
               end else if (m_occ[i] < OCC_TIMEOUT) begin
                  m_occ[i]++;
               end
            end
            default: begin
               m_left[i]--;
               if (m_left[i] == 0) m_st[i] = 0;
            end
         endcase
         e.ls[2*i +: 2] = 2'(m_st[i]);
         e.ov[i] = (m_st[i] == 1) && (m_occ[i] == OCC_TIMEOUT);
      end

      e.gw  = (gw_lav >= 0);
      e.gwl = (gw_lav >= 0) ? 2'(gw_lav) : 2'd0;
      e.gm  = (gm_lav >= 0);
      e.gml = (gm_lav >= 0) ? 2'(gm_lav) : 2'd0;
      e.qw  = 4'(m_q[0]);
      e.qm  = 4'(m_q[1]);
      e.pw  = (m_st[0] == 0) || (m_st[2] == 0);
      e.pm  = (m_st[1] == 0) || (m_st[2] == 0);
      sb.push_back(e);
   endtask

   // One clock of stimulus: drive away from the edge, queue the expectation
   task automatic cyc(input bit rw, input bit rm, input bit [2:0] vac);
      @(negedge clk_2);
      bus.req_w  = rw;
      bus.req_m  = rm;
      bus.vacate = vac;
      model_step(rw, rm, vac);
      @(posedge clk_2);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_q_w"},      int'(bus.q_w), 0);
      chk({tag, "_q_m"},      int'(bus.q_m), 0);
      chk({tag, "_grant_w"},  int'(bus.grant_w), 0);
      chk({tag, "_grant_m"},  int'(bus.grant_m), 0);
      chk({tag, "_gw_lav"},   int'(bus.grant_w_lav), 0);
      chk({tag, "_gm_lav"},   int'(bus.grant_m_lav), 0);
      chk({tag, "_drop_w"},   int'(bus.drop_w), 0);
      chk({tag, "_drop_m"},   int'(bus.drop_m), 0);
      chk({tag, "_lav_state"}, int'(bus.lav_state), 0);
      chk({tag, "_overstay"}, int'(bus.overstay), 0);
      chk({tag, "_disp_w"},   int'(bus.disp_w), 1);
      chk({tag, "_disp_m"},   int'(bus.disp_m), 1);
   endtask

   // Monitor: after every active edge compare DUT outputs to the queued result
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk_2);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("grant_w", int'(bus.grant_w), int'(e.gw));
            if (e.gw) chk("grant_w_lav", int'(bus.grant_w_lav), int'(e.gwl));
            chk("grant_m", int'(bus.grant_m), int'(e.gm));
            if (e.gm) chk("grant_m_lav", int'(bus.grant_m_lav), int'(e.gml));
            chk("q_w",       int'(bus.q_w), int'(e.qw));
            chk("q_m",       int'(bus.q_m), int'(e.qm));
            chk("drop_w",    int'(bus.drop_w), int'(e.dw));
            chk("drop_m",    int'(bus.drop_m), int'(e.dm));
            chk("lav_state", int'(bus.lav_state), int'(e.ls));
            chk("overstay",  int'(bus.overstay), int'(e.ov));
            chk("disp_w",    int'(bus.disp_w), int'(e.pw));
            chk("disp_m",    int'(bus.disp_m), int'(e.pm));
         end
      end
   end

   initial begin : stimulus
      bit       rw, rm;
      bit [2:0] vac;
      bus.req_w  = 1'b0;
      bus.req_m  = 1'b0;
      bus.vacate = 3'b000;
      model_reset();

      repeat (2) @(posedge clk_2);
      #2;
      check_reset("reset");
      @(negedge clk_2);
      rst_n = 1'b1;

      // First woman takes lav0, first man takes lav1
      cyc(1, 0, 3'b000); cyc(0, 0, 3'b000); cyc(0, 0, 3'b000);
      cyc(0, 1, 3'b000); cyc(0, 0, 3'b000); cyc(0, 0, 3'b000);
      // Both wait for the shared lavatory: women win the first conflict
      cyc(1, 1, 3'b000); cyc(0, 0, 3'b000); cyc(0, 0, 3'b000);
      // Another woman joins while lav2 cleans: men win the next conflict
      cyc(1, 0, 3'b100);
      repeat (6) cyc(0, 0, 3'b000);
      // Waiting woman gets lav0 once its cleaning completes
      cyc(0, 0, 3'b001);
      repeat (6) cyc(0, 0, 3'b000);
      // Free lav1, reoccupy it and hold past the overstay timeout
      cyc(0, 0, 3'b010);
      repeat (5) cyc(0, 0, 3'b000);
      cyc(0, 1, 3'b000);
      repeat (13) cyc(0, 0, 3'b000);
      // Fill the men queue to saturation, then arrive while a grant happens
      repeat (8) cyc(0, 1, 3'b000);
      cyc(0, 1, 3'b010);
      repeat (6) cyc(0, 1, 3'b000);

      // Randomised traffic: busy phase then lighter phase
      for (int n = 0; n < 300; n++) begin
         rw = ($urandom_range(0, 1) == 0);
         rm = ($urandom_range(0, 1) == 0);
         for (int i = 0; i < 3; i++) vac[i] = ($urandom_range(0, 9) == 0);
         cyc(rw, rm, vac);
      end
      for (int n = 0; n < 300; n++) begin
         rw = ($urandom_range(0, 3) == 0);
         rm = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 3; i++) vac[i] = ($urandom_range(0, 3) == 0);
         cyc(rw, rm, vac);
      end

      // Load everything up, start one clean, then reset between edges
      repeat (10) cyc(1, 1, 3'b000);
      cyc(0, 0, 3'b001);
      @(negedge clk_2);
      bus.req_w  = 1'b0;
      bus.req_m  = 1'b0;
      bus.vacate = 3'b000;
      #1 rst_n = 1'b0;
      #1 check_reset("midrst");
      model_reset();
      @(posedge clk_2);
      #2 check_reset("midrst_hold");
      @(negedge clk_2);
      rst_n = 1'b1;

      for (int n = 0; n < 60; n++) begin
         rw = ($urandom_range(0, 2) == 0);
         rm = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < 3; i++) vac[i] = ($urandom_range(0, 4) == 0);
         cyc(rw, rm, vac);
      end

      @(negedge clk_2);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lavatory_arbiter.md
# lavatory_arbiter

Sequential arbiter that shares the three aircraft lavatories between two passenger classes (women, men), replacing the combinational availability decode in the board top. Keeps a waiting count per class, grants free lavatories by class eligibility with round-robin on the shared lavatory, and runs a per-lavatory occupy/clean state machine with an overstay alarm. Outputs drive LED/SEG indicators and the LCD debug fields.

## Interface
- QMAX, 7: maximum waiting count per class (saturation point)
- CLEAN_CYC, 4: cycles a lavatory spends in CLEAN after vacate (≥1)
- OCC_TIMEOUT, 255: occupied cycles before overstay asserts (≥1)
- TW, 8: occupancy timer width; OCC_TIMEOUT < 2^TW
- QW, $clog2(QMAX+1): derived queue-count width

Ports:
- clk_2  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_w  in  1  one woman arrives this cycle
- req_m  in  1  one man arrives this cycle
- vacate  in  3  bit i: occupant of lavatory i leaves
- grant_w  out  1  one-cycle pulse: woman granted
- grant_w_lav  out  2  lavatory index for grant_w (0 or 2)
- grant_m  out  1  one-cycle pulse: man granted
- grant_m_lav  out  2  lavatory index for grant_m (1 or 2)
- q_w, q_m  out  QW  waiting counts
- drop_w, drop_m  out  1  pulse: arrival rejected, queue full
- lav_state  out  6  2 bits per lavatory, {lav2,lav1,lav0}; FREE=00, OCC=01, CLEAN=10
- overstay  out  3  bit i: lavatory i occupied ≥ OCC_TIMEOUT cycles
- disp_w, disp_m  out  1  an eligible lavatory is FREE

## Operation
- Eligibility: lav0 women only; lav1 men only; lav2 shared.
- Grant evaluated each cycle from registered q_* and lav_state. Women: lav0 if FREE, else lav2 if FREE. Men: lav1 if FREE, else lav2 if FREE. Requires q>0.
- Conflict (both classes want lav2): winner is class not holding rr_ptr; rr_ptr records class last granted lav2 (any grant of lav2 updates it). Reset rr_ptr = MEN, so women win first conflict.
- Both classes may be granted in the same cycle on different lavatories.
- Queue: +1 on req, −1 on grant; req and grant same cycle → unchanged. req at q=QMAX without same-class grant → drop pulse, q unchanged. req at QMAX with grant → accepted, no drop.
- Lavatory FSM: FREE → OCC on grant; OCC → CLEAN on vacate[i]; CLEAN → FREE after exactly CLEAN_CYC cycles in CLEAN. vacate in FREE/CLEAN ignored.
- Occupancy timer: cleared on entering OCC, increments each OCC cycle, saturates at OCC_TIMEOUT; overstay[i] = OCC and timer==OCC_TIMEOUT; clears on leaving OCC.
- disp_w = lav0 or lav2 FREE; disp_m = lav1 or lav2 FREE (combinational from registered state).

## Timing
- All outputs registered except disp_* (decode of registered state).
- Reset values: q_*=0, grant_*=0, grant_*_lav=0, drop_*=0, lav_state=000000, overstay=0, rr_ptr=MEN, disp_w=disp_m=1.
- req sampled at edge k → q visible after k; grant pulse, q decrement and OCC state all visible after edge k+1 (2-edge latency with free lavatory).
- vacate at edge k → CLEAN after k; FREE after edge k+CLEAN_CYC; grantable in that cycle.
- Overstay asserts after OCC_TIMEOUT edges in OCC.
- rst_n low mid-operation: everything returns to reset values immediately; pending queue lost.

## Structure
- Package lav_pkg: lav_state_t enum (FREE, OCC, CLEAN), class_t (WOMEN, MEN), lavatory index constants LAV_W=0, LAV_M=1, LAV_S=2.
- Sub-module lav_slot: one lavatory FSM, clean counter, occupancy timer, overstay; instantiated 3×. Top holds queues, grant logic, rr_ptr.

## Test plan
- Reset, then req_w=1 one cycle → q_w=1, next edge grant_w=1, grant_w_lav=0, lav_state[1:0]=OCC, q_w=0, disp_w stays 1 (lav2 free).
- lav0 and lav1 OCC, q_w=1, q_m=1 → first conflict grants women lav2; repeat after lav2 cleans → men get lav2.
- vacate[0] with CLEAN_CYC=4 → CLEAN for exactly 4 cycles, then FREE; waiting woman granted the cycle FREE is seen.
- 8 req_m with all men lavatories OCC, QMAX=7 → q_m=7, 8th cycle drop_m=1; req_m and grant_m same cycle at 7 → q_m stays 7, no drop.
- OCC_TIMEOUT=10: hold lav1 occupied → overstay[1] rises after 10 cycles, clears on vacate[1].
- rst_n low while queues nonzero and lavatories OCC/CLEAN → all outputs reset asynchronously, disp_w=disp_m=1.
